// File: rtl/cache_pkg.sv
// Shared geometry, state encoding and address helpers for the miss-status line buffer.
package cache_pkg;

  localparam int DATA_WIDTH        = 32;
  localparam int ADR_WIDTH         = 32;
  localparam int WORD_OFFSET_WIDTH = 2;
  localparam int WORD_NUM          = 4;
  localparam int LINE_ADR_WIDTH    = ADR_WIDTH - WORD_OFFSET_WIDTH;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    WB      = 3'd2,
    FILL    = 3'd3,
    READY   = 3'd4
  } state_e;

  // Upper address bits that identify a line; the word offset is shifted away.
  function automatic logic [LINE_ADR_WIDTH-1:0] line_base(input logic [ADR_WIDTH-1:0] adr);
    return LINE_ADR_WIDTH'(adr >> WORD_OFFSET_WIDTH);
  endfunction

  function automatic logic [WORD_NUM-1:0] word_onehot(input logic [WORD_OFFSET_WIDTH-1:0] idx);
    return {{(WORD_NUM-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/line_buf.sv
// One cache line of storage: single write port, async read port, per-word valid mask with clear.
module line_buf
  import cache_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_we,
  input  logic [WORD_OFFSET_WIDTH-1:0] i_wadr,
  input  logic [DATA_WIDTH-1:0]        i_wdat,
  input  logic                         i_clr,
  input  logic [WORD_OFFSET_WIDTH-1:0] i_radr,
  output logic [DATA_WIDTH-1:0]        o_rdat,
  output logic [WORD_NUM-1:0]          o_valid
);

  logic [DATA_WIDTH-1:0] r_mem [WORD_NUM];
  logic [WORD_NUM-1:0]   r_valid;
  logic [WORD_NUM-1:0]   w_set;

  assign w_set   = i_we ? word_onehot(i_wadr) : {WORD_NUM{1'b0}};
  assign o_rdat  = r_mem[i_radr];
  assign o_valid = r_valid;

  // Word storage; a clear drops the mask but a write in the same cycle still lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WORD_NUM; i++) begin
        r_mem[i] <= {DATA_WIDTH{1'b0}};
      end
      r_valid <= {WORD_NUM{1'b0}};
    end else begin
      if (i_we) begin
        r_mem[i_wadr] <= i_wdat;
      end
      r_valid <= (i_clr ? {WORD_NUM{1'b0}} : r_valid) | w_set;
    end
  end

endmodule

// File: rtl/mshr_line_buffer.sv
// Single-entry MSHR: captures a dirty victim, writes it back, then fetches the missing line.
// Build option: CRITICAL_WORD_FIRST_EN starts the fill at the requested word.
module mshr_line_buffer
  import cache_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         miss_req_i,
  input  logic [ADR_WIDTH-1:0]         miss_adr_i,
  input  logic                         victim_dirty_i,
  input  logic [ADR_WIDTH-1:0]         victim_adr_i,
  input  logic                         victim_we_i,
  input  logic [WORD_OFFSET_WIDTH-1:0] victim_word_i,
  input  logic [DATA_WIDTH-1:0]        victim_dat_i,
  input  logic [WORD_OFFSET_WIDTH-1:0] refill_word_i,
  output logic [DATA_WIDTH-1:0]        refill_dat_o,
  output logic [ADR_WIDTH-1:0]         refill_adr_o,
  output logic [WORD_NUM-1:0]          word_valid_o,
  output logic                         refill_ready_o,
  input  logic                         refill_done_i,
  output logic                         busy_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [ADR_WIDTH-1:0]         mem_adr_o,
  output logic [DATA_WIDTH-1:0]        mem_dat_o,
  input  logic                         mem_ack_i,
  input  logic [DATA_WIDTH-1:0]        mem_dat_i
);

  state_e                       r_state;
  logic [ADR_WIDTH-1:0]         r_miss_adr;
  logic [ADR_WIDTH-1:0]         r_victim_adr;
  logic [WORD_OFFSET_WIDTH-1:0] r_beat;
  logic [WORD_OFFSET_WIDTH-1:0] r_fcnt;
  logic                         r_mem_req;
  logic                         r_mem_we;

  logic                         w_ack;
  logic                         w_accept;
  logic                         w_vic_we;
  logic                         w_fill_we;
  logic                         w_fill_clr;
  logic                         w_last_beat;
  logic [WORD_NUM-1:0]          w_vic_valid;
  logic [WORD_NUM-1:0]          w_vic_mask_next;
  logic [DATA_WIDTH-1:0]        w_vic_dat;
  logic [WORD_OFFSET_WIDTH-1:0] w_fill_start;

  assign w_ack           = mem_ack_i & r_mem_req;
  assign w_accept        = miss_req_i & (r_state == IDLE);
  assign w_vic_we        = victim_we_i & (r_state == CAPTURE);
  assign w_fill_we       = w_ack & (r_state == FILL);
  assign w_fill_clr      = refill_done_i & (r_state == READY);
  assign w_last_beat     = (r_beat == {WORD_OFFSET_WIDTH{1'b1}});
  assign w_vic_mask_next = w_vic_valid | (w_vic_we ? word_onehot(victim_word_i) : {WORD_NUM{1'b0}});

`ifdef CRITICAL_WORD_FIRST_EN
  assign w_fill_start = miss_adr_i[WORD_OFFSET_WIDTH-1:0];
`else
  assign w_fill_start = {WORD_OFFSET_WIDTH{1'b0}};
`endif

  line_buf u_victim (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_vic_we),
    .i_wadr  (victim_word_i),
    .i_wdat  (victim_dat_i),
    .i_clr   (w_accept),
    .i_radr  (r_beat),
    .o_rdat  (w_vic_dat),
    .o_valid (w_vic_valid)
  );

  line_buf u_fill (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_fill_we),
    .i_wadr  (r_fcnt),
    .i_wdat  (mem_dat_i),
    .i_clr   (w_fill_clr),
    .i_radr  (refill_word_i),
    .o_rdat  (refill_dat_o),
    .o_valid (word_valid_o)
  );

  // Control FSM; mem_req/mem_we are registered and dropped for one cycle between WB and FILL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_miss_adr   <= {ADR_WIDTH{1'b0}};
      r_victim_adr <= {ADR_WIDTH{1'b0}};
      r_beat       <= {WORD_OFFSET_WIDTH{1'b0}};
      r_fcnt       <= {WORD_OFFSET_WIDTH{1'b0}};
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_miss_adr   <= miss_adr_i;
            r_victim_adr <= victim_adr_i;
            r_fcnt       <= w_fill_start;
            r_beat       <= {WORD_OFFSET_WIDTH{1'b0}};
            if (victim_dirty_i) begin
              r_state <= CAPTURE;
            end else begin
              r_state   <= FILL;
              r_mem_req <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (&w_vic_mask_next) begin
            r_state   <= WB;
            r_mem_req <= 1'b1;
            r_mem_we  <= 1'b1;
            r_beat    <= {WORD_OFFSET_WIDTH{1'b0}};
          end
        end
        WB: begin
          if (w_ack) begin
            r_beat <= r_beat + 1'b1;
            if (w_last_beat) begin
              r_state   <= FILL;
              r_mem_req <= 1'b0;
              r_mem_we  <= 1'b0;
            end
          end
        end
        FILL: begin
          if (!r_mem_req) begin
            r_mem_req <= 1'b1;
          end else if (w_ack) begin
            r_fcnt <= r_fcnt + 1'b1;
            r_beat <= r_beat + 1'b1;
            if (w_last_beat) begin
              r_state   <= READY;
              r_mem_req <= 1'b0;
            end
          end
        end
        READY: begin
          if (refill_done_i) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  // Memory address/data decode; held stable because only an ack moves the counters.
  always_comb begin
    mem_adr_o = {ADR_WIDTH{1'b0}};
    mem_dat_o = {DATA_WIDTH{1'b0}};
    case (r_state)
      WB: begin
        mem_adr_o = {line_base(r_victim_adr), r_beat};
        mem_dat_o = w_vic_dat;
      end
      FILL: begin
        mem_adr_o = {line_base(r_miss_adr), r_fcnt};
      end
      default: begin
        mem_adr_o = {ADR_WIDTH{1'b0}};
        mem_dat_o = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  assign mem_req_o      = r_mem_req;
  assign mem_we_o       = r_mem_we;
  assign refill_adr_o   = r_miss_adr;
  assign refill_ready_o = (r_state == READY);
  assign busy_o         = (r_state != IDLE);

endmodule

// File: tb/tb_mshr_line_buffer.sv
// Self-checking bench for mshr_line_buffer: directed vector table, random misses, reset mid-writeback.
module tb_mshr_line_buffer;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss_req_i = 1'b0;
  logic [31:0] miss_adr_i = 32'h0;
  logic        victim_dirty_i = 1'b0;
  logic [31:0] victim_adr_i = 32'h0;
  logic        victim_we_i = 1'b0;
  logic [1:0]  victim_word_i = 2'd0;
  logic [31:0] victim_dat_i = 32'h0;
  logic [1:0]  refill_word_i = 2'd0;
  logic [31:0] refill_dat_o;
  logic [31:0] refill_adr_o;
  logic [3:0]  word_valid_o;
  logic        refill_ready_o;
  logic        refill_done_i = 1'b0;
  logic        busy_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_adr_o;
  logic [31:0] mem_dat_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_dat_i = 32'h0;

  mshr_line_buffer dut (
    .clk(clk), .rst(rst), .miss_req_i(miss_req_i), .miss_adr_i(miss_adr_i),
    .victim_dirty_i(victim_dirty_i), .victim_adr_i(victim_adr_i), .victim_we_i(victim_we_i),
    .victim_word_i(victim_word_i), .victim_dat_i(victim_dat_i), .refill_word_i(refill_word_i),
    .refill_dat_o(refill_dat_o), .refill_adr_o(refill_adr_o), .word_valid_o(word_valid_o),
    .refill_ready_o(refill_ready_o), .refill_done_i(refill_done_i), .busy_o(busy_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o),
    .mem_ack_i(mem_ack_i), .mem_dat_i(mem_dat_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      miss_adr;
    logic             dirty;
    logic [31:0]      victim_adr;
    logic [3:0][31:0] vdat;
    logic [3:0][1:0]  order;
    int               delay;
    bit               stray;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } beat_t;

  vec_t  vecs[5];
  beat_t exp_q[$];
  beat_t got_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Main memory contents: test-plan words near 0x104, a fixed scramble elsewhere.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a >= 32'h104 && a <= 32'h107) return 32'hA0 + (a - 32'h104);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic int fill_start(input logic [31:0] a);
`ifdef CRITICAL_WORD_FIRST_EN
    return int'(a % 4);
`else
    return 0;
`endif
  endfunction

  // Reference: dirty victim goes out word 0..3, then the four line words starting at fill_start.
  task automatic build_expected(input vec_t v);
    logic [31:0] vb, mb, a;
    exp_q.delete();
    vb = v.victim_adr & ~32'h3;
    mb = v.miss_adr & ~32'h3;
    if (v.dirty) begin
      for (int i = 0; i < 4; i++) exp_q.push_back('{1'b1, vb + i, v.vdat[i]});
    end
    for (int i = 0; i < 4; i++) begin
      a = mb + ((fill_start(v.miss_adr) + i) % 4);
      exp_q.push_back('{1'b0, a, mem_model(a)});
    end
  endtask

  task automatic start_miss(input vec_t v);
    miss_req_i = 1'b1; miss_adr_i = v.miss_adr;
    victim_dirty_i = v.dirty; victim_adr_i = v.victim_adr;
    cycle();
    miss_req_i = 1'b0; victim_dirty_i = 1'b0;
    check("busy_after_accept", busy_o, 1);
  endtask

  task automatic capture(input vec_t v);
    victim_we_i = 1'b1;
    victim_word_i = v.order[0];
    victim_dat_i = ~v.vdat[v.order[0]];
    cycle();
    for (int k = 0; k < 4; k++) begin
      victim_word_i = v.order[k];
      victim_dat_i = v.vdat[v.order[k]];
      cycle();
    end
    victim_we_i = 1'b0;
  endtask

  task automatic run_miss(input vec_t v);
    int          wait_n;
    int          budget;
    bit          prev_stall;
    bit          first_rd_done;
    bit          rd_acked;
    logic [31:0] prev_adr, prev_dat;
    logic [31:0] mb;
    got_q.delete();
    build_expected(v);
    mb = v.miss_adr & ~32'h3;
    start_miss(v);
    if (v.dirty) capture(v);
    wait_n = 0; prev_stall = 0; first_rd_done = 0;
    for (budget = 0; budget < 3000 && !refill_ready_o; budget++) begin
      mem_ack_i = 1'b0; miss_req_i = 1'b0; refill_done_i = 1'b0; victim_we_i = 1'b0;
      rd_acked = 0;
      if (mem_req_o) begin
        if (prev_stall) begin
          check("stall_adr", mem_adr_o, prev_adr);
          check("stall_dat", mem_dat_o, prev_dat);
        end
        if (wait_n >= v.delay) begin
          mem_ack_i = 1'b1;
          mem_dat_i = mem_we_o ? $urandom : mem_model(mem_adr_o);
          got_q.push_back('{mem_we_o, mem_adr_o, mem_we_o ? mem_dat_o : mem_dat_i});
          rd_acked = !mem_we_o;
          wait_n = 0; prev_stall = 0;
        end else begin
          wait_n++; prev_stall = 1; prev_adr = mem_adr_o; prev_dat = mem_dat_o;
        end
      end else begin
        prev_stall = 0;
        if (v.stray) begin mem_ack_i = 1'b1; mem_dat_i = $urandom; end
      end
      if (v.stray) begin
        victim_we_i = 1'b1; victim_word_i = 2'($urandom); victim_dat_i = $urandom;
        if (mem_req_o && !mem_we_o) begin
          miss_req_i = 1'b1; miss_adr_i = $urandom; victim_dirty_i = 1'b1; refill_done_i = 1'b1;
        end
      end
      cycle();
      if (rd_acked && !first_rd_done) begin
        first_rd_done = 1;
        check("first_word_valid", word_valid_o, 4'b0001 << fill_start(v.miss_adr));
      end
    end
    mem_ack_i = 1'b0; miss_req_i = 1'b0; refill_done_i = 1'b0; victim_we_i = 1'b0;
    victim_dirty_i = 1'b0;
    check("ready_reached", refill_ready_o, 1);
    check("ready_mem_req", mem_req_o, 0);
    check("ready_busy", busy_o, 1);
    check("word_valid_full", word_valid_o, 4'hF);
    check("refill_adr", refill_adr_o, v.miss_adr);
    check("beat_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check("beat_we", got_q[i].we, exp_q[i].we);
      check("beat_adr", got_q[i].adr, exp_q[i].adr);
      check("beat_dat", got_q[i].dat, exp_q[i].dat);
    end
    for (int w = 0; w < 4; w++) begin
      refill_word_i = 2'(w);
      #1;
      check("refill_dat", refill_dat_o, mem_model(mb + w));
    end
    refill_done_i = 1'b1; miss_req_i = 1'b1; miss_adr_i = 32'h0000_0F00;
    cycle();
    refill_done_i = 1'b0; miss_req_i = 1'b0;
    check("release_busy", busy_o, 0);
    check("release_valid", word_valid_o, 4'h0);
    check("release_ready", refill_ready_o, 0);
    cycle();
    check("same_cycle_miss_ignored", busy_o, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_mem_req"}, mem_req_o, 0);
    check({tag, "_mem_we"}, mem_we_o, 0);
    check({tag, "_mem_adr"}, mem_adr_o, 0);
    check({tag, "_mem_dat"}, mem_dat_o, 0);
    check({tag, "_ready"}, refill_ready_o, 0);
    check({tag, "_valid"}, word_valid_o, 0);
    check({tag, "_refill_adr"}, refill_adr_o, 0);
    check({tag, "_refill_dat"}, refill_dat_o, 0);
  endtask

  initial begin
    int acks;
    vec_t rv;
    int p[4];
    int j, t;

    vecs[0] = '{32'h0000_0105, 1'b0, 32'h0000_0000, {32'h0, 32'h0, 32'h0, 32'h0},
                {2'd3, 2'd2, 2'd1, 2'd0}, 0, 1'b0};
    vecs[1] = '{32'h0000_0333, 1'b1, 32'h0000_0200, {32'hD3, 32'hD2, 32'hD1, 32'hD0},
                {2'd2, 2'd0, 2'd1, 2'd3}, 1, 1'b0};
    vecs[2] = '{32'h1234_5678, 1'b1, 32'h0ABC_DEF0, {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000},
                {2'd0, 2'd1, 2'd2, 2'd3}, 5, 1'b0};
    vecs[3] = '{32'h0000_0AAA, 1'b0, 32'h0000_0000, {32'h0, 32'h0, 32'h0, 32'h0},
                {2'd3, 2'd2, 2'd1, 2'd0}, 2, 1'b1};
    vecs[4] = '{32'h0000_0107, 1'b0, 32'h0000_0000, {32'h0, 32'h0, 32'h0, 32'h0},
                {2'd3, 2'd2, 2'd1, 2'd0}, 0, 1'b0};

    cycle();
    check_all_zero("reset");
    rst = 1'b1;
    cycle();

    for (int i = 0; i < 5; i++) run_miss(vecs[i]);

    // Reset after two writeback acks abandons the entry immediately.
    start_miss(vecs[1]);
    capture(vecs[1]);
    acks = 0;
    for (int b = 0; b < 50 && acks < 2; b++) begin
      mem_ack_i = mem_req_o;
      if (mem_req_o) acks++;
      cycle();
    end
    mem_ack_i = 1'b0;
    check("mid_wb_we", mem_we_o, 1);
    check("mid_wb_adr", mem_adr_o, 32'h0000_0202);
    #2 rst = 1'b0;
    #1 check_all_zero("async_reset");
    cycle();
    rst = 1'b1;
    cycle();
    run_miss(vecs[0]);

    for (int r = 0; r < 30; r++) begin
      rv.miss_adr = $urandom;
      rv.dirty = 1'($urandom_range(0, 1));
      rv.victim_adr = $urandom;
      for (int k = 0; k < 4; k++) begin rv.vdat[k] = $urandom; p[k] = k; end
      for (int k = 3; k > 0; k--) begin
        j = $urandom_range(0, k); t = p[k]; p[k] = p[j]; p[j] = t;
      end
      for (int k = 0; k < 4; k++) rv.order[k] = 2'(p[k]);
      rv.delay = $urandom_range(0, 3);
      rv.stray = 1'($urandom_range(0, 1));
      run_miss(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mshr_line_buffer.md
Name: mshr_line_buffer

Overview:
- Single-entry miss-status/line buffer between the 4-way cache controller and main memory.
- On a miss it captures the evicted victim line from the cache and writes it back to memory if it is dirty.
- It then fetches the missing line from memory one word per handshake and holds it so the cache can refill by word index.
- Addresses are word addresses: the tag, index and word-offset fields fill ADR_WIDTH, with no byte offset.

Parameters:
- DATA_WIDTH, 32, data word width
- ADR_WIDTH, 32, word-address width
- WORD_OFFSET_WIDTH, 2, word-in-line index width
- WORD_NUM, 4, words per line; must equal 2**WORD_OFFSET_WIDTH

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous active-low reset
- miss_req_i  input  1  one-cycle miss request pulse
- miss_adr_i  input  ADR_WIDTH  missing word address
- victim_dirty_i  input  1  victim line valid and dirty; sampled with miss_req_i
- victim_adr_i  input  ADR_WIDTH  victim line base address; sampled with miss_req_i
- victim_we_i  input  1  victim word write strobe
- victim_word_i  input  WORD_OFFSET_WIDTH  victim word index
- victim_dat_i  input  DATA_WIDTH  victim word data
- refill_word_i  input  WORD_OFFSET_WIDTH  word index the cache is reading
- refill_dat_o  output  DATA_WIDTH  fill-buffer word at refill_word_i (combinational)
- refill_adr_o  output  ADR_WIDTH  latched miss address
- word_valid_o  output  WORD_NUM  per-word fill-valid mask
- refill_ready_o  output  1  all fill words present
- refill_done_i  input  1  cache finished refilling; releases the entry
- busy_o  output  1  entry occupied
- mem_req_o  output  1  memory request
- mem_we_o  output  1  1 = write, 0 = read
- mem_adr_o  output  ADR_WIDTH  memory word address
- mem_dat_o  output  DATA_WIDTH  write data
- mem_ack_i  input  1  memory acknowledge; read data valid in the same cycle
- mem_dat_i  input  DATA_WIDTH  read data

Behaviour:
- Reset (rst = 0, asynchronous):
  - state goes to IDLE; masks and counters are cleared.
  - All outputs go to 0, and refill_dat_o reads the cleared buffer, i.e. 0.
  - Any in-flight transaction is abandoned; memory must tolerate a dropped mem_req_o.
- States: IDLE, CAPTURE, WB, FILL, READY.
- IDLE:
  - miss_req_i = 1 latches miss_adr_i, victim_adr_i and victim_dirty_i, then moves to CAPTURE if victim_dirty_i = 1, otherwise to FILL.
  - busy_o rises the cycle after acceptance.
- CAPTURE:
  - victim_we_i writes victim_dat_i into victim buffer slot victim_word_i and sets that slot's capture-mask bit.
  - A repeated index overwrites the slot.
  - When the mask is all ones (checked including the current write), the next state is WB.
- WB:
  - mem_req_o = 1, mem_we_o = 1.
  - mem_adr_o = {victim base[ADR_WIDTH-1:WORD_OFFSET_WIDTH], wcnt}; mem_dat_o = victim slot wcnt.
  - The 2-bit wcnt starts at 0 and advances on each mem_ack_i.
  - Address and data are held stable until ack.
  - After the ack for word WORD_NUM-1, move to FILL.
- FILL:
  - mem_req_o = 1, mem_we_o = 0, mem_adr_o = {miss base, fcnt}.
  - On mem_ack_i, mem_dat_i is written into slot fcnt and word_valid_o[fcnt] is set next cycle; fcnt then advances, wrapping 3 -> 0.
  - After WORD_NUM acks, move to READY.
- READY:
  - refill_ready_o = 1 and mem_req_o = 0.
  - refill_done_i = 1 moves to IDLE. The next cycle clears busy_o, refill_ready_o and word_valid_o.
- mem_req_o is registered. It stays high across consecutive beats within WB and within FILL, and drops for one cycle at the WB -> FILL transition.
- Boundary conditions:
  - miss_req_i while busy_o = 1 is ignored.
  - victim_we_i outside CAPTURE is ignored.
  - mem_ack_i while mem_req_o = 0 is ignored.
  - refill_done_i outside READY is ignored.
  - miss_req_i in the same cycle as refill_done_i (in READY) is ignored; the new miss is accepted the following cycle.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined:
  - fcnt starts at miss_adr_i[WORD_OFFSET_WIDTH-1:0] and wraps modulo WORD_NUM.
  - The requested word therefore arrives first, and word_valid_o exposes it early so the cache can ack the CPU before refill_ready_o.
- Undefined: fcnt always starts at 0.
- WB order is 0..3 in both cases.

Decomposition:
- Shared package (cache_pkg):
  - DATA_WIDTH, ADR_WIDTH, WORD_OFFSET_WIDTH, WORD_NUM
  - the state enum {IDLE, CAPTURE, WB, FILL, READY}
  - a line-base extraction function
- Sub-module line_buf: WORD_NUM x DATA_WIDTH register file with one write port, one async read port and a per-word valid mask with clear.
- Two line_buf instances: victim and fill.

Test Plan:
- Clean miss: miss_adr=0x00000105, victim_dirty=0; memory returns 0xA0..0xA3 for addresses 0x104..0x107 -> no write beats; reads occur in order 0x104, 0x105, 0x106, 0x107; refill_ready=1; refill_word=2 gives 0xA2.
- Dirty miss: victim_adr=0x00000200; capture words 3,1,0,2 with data 0xD3, 0xD1, 0xD0, 0xD2 -> writes to 0x200..0x203 carry 0xD0..0xD3 in order, followed by 4 reads.
- Memory stalls: ack delayed 5 cycles per beat -> mem_adr_o and mem_dat_o stable throughout each stall; exactly 4 beats per phase.
- Busy/ignore: second miss_req while in FILL, plus a stray mem_ack with mem_req=0 -> no state change; refill_adr_o unchanged.
- Reset mid-WB after 2 acks -> all outputs 0 immediately; a new clean miss then completes normally.
- With CRITICAL_WORD_FIRST_EN and miss_adr=0x107 -> read order 0x107, 0x104, 0x105, 0x106; word_valid_o=4'b1000 after the first ack.
